// File: rtl/sysp_icb_arb.sv
// sysp_icb_arb: round-robin ICB arbiter sharing the sysp slave port
// between two masters, with one outstanding read and a response watchdog.
module sysp_icb_arb #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int TO_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            m0_icb_cmd_valid,
    output logic            m0_icb_cmd_ready,
    input  logic [AW-1:0]   m0_icb_cmd_addr,
    input  logic            m0_icb_cmd_read,
    input  logic [DW-1:0]   m0_icb_cmd_wdata,
    input  logic [DW/8-1:0] m0_icb_cmd_wmask,
    output logic            m0_icb_rsp_valid,
    input  logic            m0_icb_rsp_ready,
    output logic            m0_icb_rsp_err,
    output logic [DW-1:0]   m0_icb_rsp_rdata,

    input  logic            m1_icb_cmd_valid,
    output logic            m1_icb_cmd_ready,
    input  logic [AW-1:0]   m1_icb_cmd_addr,
    input  logic            m1_icb_cmd_read,
    input  logic [DW-1:0]   m1_icb_cmd_wdata,
    input  logic [DW/8-1:0] m1_icb_cmd_wmask,
    output logic            m1_icb_rsp_valid,
    input  logic            m1_icb_rsp_ready,
    output logic            m1_icb_rsp_err,
    output logic [DW-1:0]   m1_icb_rsp_rdata,

    output logic            s_icb_cmd_valid,
    input  logic            s_icb_cmd_ready,
    output logic [AW-1:0]   s_icb_cmd_addr,
    output logic            s_icb_cmd_read,
    output logic [DW-1:0]   s_icb_cmd_wdata,
    output logic [DW/8-1:0] s_icb_cmd_wmask,
    input  logic            s_icb_rsp_valid,
    output logic            s_icb_rsp_ready,
    input  logic            s_icb_rsp_err,
    input  logic [DW-1:0]   s_icb_rsp_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RSP = 2'd1,
        ERR_RSP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_owner;
    logic        r_prio;
    logic        r_lock;
    logic        r_lock_id;
    logic [7:0]  r_to_cnt;
    logic        w_owner_nxt;
    logic        w_prio_nxt;
    logic        w_lock_nxt;
    logic        w_lock_id_nxt;
    logic [7:0]  w_to_cnt_nxt;

    logic        w_idle;
    logic        w_grant;
    logic        w_gnt_valid;
    logic        w_cmd_hs;
    logic        w_own_rdy;
    logic        w_rsp_vld;
    logic        w_rsp_err;
    logic [DW-1:0] w_rsp_rdata;
    logic        w_s_rsp_rdy;

    // A stalled command keeps its grant until the slave takes it.
    always_comb begin
        w_grant = r_prio;
        if (r_lock)
            w_grant = r_lock_id;
        else if (m0_icb_cmd_valid && !m1_icb_cmd_valid)
            w_grant = 1'b0;
        else if (m1_icb_cmd_valid && !m0_icb_cmd_valid)
            w_grant = 1'b1;
    end

    // Gating with rst_n forces the command outputs quiet during reset.
    assign w_idle      = (r_state == IDLE) && rst_n;
    assign w_gnt_valid = w_grant ? m1_icb_cmd_valid : m0_icb_cmd_valid;

    assign s_icb_cmd_valid = w_idle && w_gnt_valid;
    assign s_icb_cmd_addr  = w_grant ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign s_icb_cmd_read  = w_grant ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign s_icb_cmd_wdata = w_grant ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign s_icb_cmd_wmask = w_grant ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

    assign w_cmd_hs = s_icb_cmd_valid && s_icb_cmd_ready;

    assign m0_icb_cmd_ready = w_idle && !w_grant && m0_icb_cmd_valid
                              && s_icb_cmd_ready;
    assign m1_icb_cmd_ready = w_idle && w_grant && m1_icb_cmd_valid
                              && s_icb_cmd_ready;

    assign w_own_rdy = r_owner ? m1_icb_rsp_ready : m0_icb_rsp_ready;

    always_comb begin
        w_rsp_vld   = 1'b0;
        w_rsp_err   = 1'b0;
        w_rsp_rdata = '0;
        w_s_rsp_rdy = 1'b1;
        case (r_state)
            WAIT_RSP: begin
                w_rsp_vld   = s_icb_rsp_valid;
                w_rsp_err   = s_icb_rsp_err;
                w_rsp_rdata = s_icb_rsp_rdata;
                w_s_rsp_rdy = w_own_rdy;
            end
            ERR_RSP: begin
                w_rsp_vld = 1'b1;
                w_rsp_err = 1'b1;
            end
            default: ;
        endcase
    end

    assign s_icb_rsp_ready  = w_s_rsp_rdy;
    assign m0_icb_rsp_valid = w_rsp_vld && !r_owner;
    assign m0_icb_rsp_err   = w_rsp_err && !r_owner;
    assign m0_icb_rsp_rdata = r_owner ? '0 : w_rsp_rdata;
    assign m1_icb_rsp_valid = w_rsp_vld && r_owner;
    assign m1_icb_rsp_err   = w_rsp_err && r_owner;
    assign m1_icb_rsp_rdata = r_owner ? w_rsp_rdata : '0;

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_prio_nxt    = r_prio;
        w_lock_nxt    = r_lock;
        w_lock_id_nxt = r_lock_id;
        w_to_cnt_nxt  = r_to_cnt;
        case (r_state)
            IDLE: begin
                if (w_cmd_hs) begin
                    w_prio_nxt = ~w_grant;
                    w_lock_nxt = 1'b0;
                    if (s_icb_cmd_read) begin
                        w_owner_nxt  = w_grant;
                        w_to_cnt_nxt = 8'd0;
                        w_state_nxt  = WAIT_RSP;
                    end
                end else if (s_icb_cmd_valid) begin
                    w_lock_nxt    = 1'b1;
                    w_lock_id_nxt = w_grant;
                end
            end
            WAIT_RSP: begin
                if (s_icb_rsp_valid) begin
                    if (w_own_rdy)
                        w_state_nxt = IDLE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = ERR_RSP;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 8'd1;
                end
            end
            ERR_RSP: begin
                if (w_own_rdy)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_owner   <= 1'b0;
            r_prio    <= 1'b0;
            r_lock    <= 1'b0;
            r_lock_id <= 1'b0;
            r_to_cnt  <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_prio    <= w_prio_nxt;
            r_lock    <= w_lock_nxt;
            r_lock_id <= w_lock_id_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_sysp_icb_arb.sv
// tb_sysp_icb_arb: scoreboard bench for the sysp two-master arbiter
// with a 1-cycle slave model that returns the read address as rdata.
module tb_sysp_icb_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
    logic [AW-1:0]   m0_icb_cmd_addr;
    logic [DW-1:0]   m0_icb_cmd_wdata;
    logic [DW/8-1:0] m0_icb_cmd_wmask;
    logic            m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
    logic [DW-1:0]   m0_icb_rsp_rdata;
    logic            m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
    logic [AW-1:0]   m1_icb_cmd_addr;
    logic [DW-1:0]   m1_icb_cmd_wdata;
    logic [DW/8-1:0] m1_icb_cmd_wmask;
    logic            m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
    logic [DW-1:0]   m1_icb_rsp_rdata;
    logic            s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
    logic [AW-1:0]   s_icb_cmd_addr;
    logic [DW-1:0]   s_icb_cmd_wdata;
    logic [DW/8-1:0] s_icb_cmd_wmask;
    logic            s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err;
    logic [DW-1:0]   s_icb_rsp_rdata;

    sysp_icb_arb #(.AW(AW), .DW(DW), .TO_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
        .m0_icb_cmd_addr(m0_icb_cmd_addr), .m0_icb_cmd_read(m0_icb_cmd_read),
        .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
        .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
        .m0_icb_rsp_err(m0_icb_rsp_err), .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
        .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
        .m1_icb_cmd_addr(m1_icb_cmd_addr), .m1_icb_cmd_read(m1_icb_cmd_read),
        .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
        .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
        .m1_icb_rsp_err(m1_icb_rsp_err), .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
        .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
        .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
        .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
        .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
        .s_icb_rsp_err(s_icb_rsp_err), .s_icb_rsp_rdata(s_icb_rsp_rdata)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [33:0] sb_q[$];
    int gnt_log[$];
    logic auto_rsp;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rsp_mon(input logic id, input logic err,
                           input logic [31:0] rd);
        logic [33:0] e;
        chk("rsp pending", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("rsp owner", 64'(id), 64'(e[33]));
            chk("rsp err", 64'(err), 64'(e[32]));
            chk("rsp rdata", 64'(rd), 64'(e[31:0]));
        end
    endtask

    // One clock: monitor at negedge, then slave model after posedge.
    task automatic tick();
        logic rd_hs, s_hs;
        logic [31:0] a;
        @(negedge clk);
        rd_hs = s_icb_cmd_valid && s_icb_cmd_ready && s_icb_cmd_read;
        a     = s_icb_cmd_addr;
        s_hs  = s_icb_rsp_valid && s_icb_rsp_ready;
        if (m0_icb_cmd_valid && m0_icb_cmd_ready) begin
            gnt_log.push_back(0);
            if (m0_icb_cmd_read)
                sb_q.push_back({1'b0, !auto_rsp,
                                auto_rsp ? m0_icb_cmd_addr : 32'h0});
        end
        if (m1_icb_cmd_valid && m1_icb_cmd_ready) begin
            gnt_log.push_back(1);
            if (m1_icb_cmd_read)
                sb_q.push_back({1'b1, !auto_rsp,
                                auto_rsp ? m1_icb_cmd_addr : 32'h0});
        end
        if (m0_icb_rsp_valid && m0_icb_rsp_ready)
            rsp_mon(1'b0, m0_icb_rsp_err, m0_icb_rsp_rdata);
        if (m1_icb_rsp_valid && m1_icb_rsp_ready)
            rsp_mon(1'b1, m1_icb_rsp_err, m1_icb_rsp_rdata);
        @(posedge clk);
        #1;
        if (s_hs) s_icb_rsp_valid = 1'b0;
        if (rd_hs && auto_rsp) begin
            s_icb_rsp_valid = 1'b1;
            s_icb_rsp_rdata = a;
            s_icb_rsp_err   = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0;
        auto_rsp = 1'b1;
        m0_icb_cmd_valid = 1'b1; m0_icb_cmd_read = 1'b1;
        m0_icb_cmd_addr = '0; m0_icb_cmd_wdata = '0; m0_icb_cmd_wmask = '0;
        m1_icb_cmd_valid = 1'b1; m1_icb_cmd_read = 1'b1;
        m1_icb_cmd_addr = '0; m1_icb_cmd_wdata = '0; m1_icb_cmd_wmask = '0;
        m0_icb_rsp_ready = 1'b1; m1_icb_rsp_ready = 1'b1;
        s_icb_cmd_ready = 1'b1;
        s_icb_rsp_valid = 1'b0; s_icb_rsp_err = 1'b0; s_icb_rsp_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst m0 cmd_ready", 64'(m0_icb_cmd_ready), 64'd0);
        chk("rst m1 cmd_ready", 64'(m1_icb_cmd_ready), 64'd0);
        chk("rst s cmd_valid", 64'(s_icb_cmd_valid), 64'd0);
        chk("rst m0 rsp_valid", 64'(m0_icb_rsp_valid), 64'd0);
        chk("rst m1 rsp_valid", 64'(m1_icb_rsp_valid), 64'd0);
        chk("rst m0 rsp_err", 64'(m0_icb_rsp_err), 64'd0);
        chk("rst s rsp_ready", 64'(s_icb_rsp_ready), 64'd1);
        m0_icb_cmd_valid = 1'b0;
        m1_icb_cmd_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // both masters reading back to back
        gnt_log.delete();
        m0_icb_cmd_valid = 1'b1; m0_icb_cmd_read = 1'b1;
        m0_icb_cmd_addr = 32'h000;
        m1_icb_cmd_valid = 1'b1; m1_icb_cmd_read = 1'b1;
        m1_icb_cmd_addr = 32'h100;
        repeat (8) tick();
        m0_icb_cmd_valid = 1'b0;
        m1_icb_cmd_valid = 1'b0;
        tick();
        chk("rr reads in 8 cyc", 64'(gnt_log.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < gnt_log.size())
                chk("rr order", 64'(gnt_log[i]), 64'(i % 2));

        // lock: m1 stalled by slave, m0 must wait
        s_icb_cmd_ready = 1'b0;
        m1_icb_cmd_valid = 1'b1; m1_icb_cmd_read = 1'b0;
        m1_icb_cmd_addr = 32'h200; m1_icb_cmd_wdata = 32'h11;
        m1_icb_cmd_wmask = 4'hF;
        #2;
        chk("lock s addr", 64'(s_icb_cmd_addr), 64'h200);
        chk("lock s valid", 64'(s_icb_cmd_valid), 64'd1);
        tick();
        m0_icb_cmd_valid = 1'b1; m0_icb_cmd_read = 1'b0;
        m0_icb_cmd_addr = 32'h300; m0_icb_cmd_wdata = 32'h22;
        m0_icb_cmd_wmask = 4'hF;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("lock hold addr", 64'(s_icb_cmd_addr), 64'h200);
            chk("lock hold wdata", 64'(s_icb_cmd_wdata), 64'h11);
            chk("lock m0 ready", 64'(m0_icb_cmd_ready), 64'd0);
            tick();
        end
        s_icb_cmd_ready = 1'b1;
        #2;
        chk("lock m1 hs", 64'(m1_icb_cmd_ready), 64'd1);
        chk("lock m0 still blocked", 64'(m0_icb_cmd_ready), 64'd0);
        tick();
        m1_icb_cmd_valid = 1'b0;
        #2;
        chk("post lock addr", 64'(s_icb_cmd_addr), 64'h300);
        chk("post lock m0 ready", 64'(m0_icb_cmd_ready), 64'd1);
        tick();
        m0_icb_cmd_valid = 1'b0;

        // m0 writes, one per cycle, no response
        m0_icb_cmd_valid = 1'b1; m0_icb_cmd_read = 1'b0;
        m0_icb_cmd_addr = 32'h0000_0F04; m0_icb_cmd_wdata = 32'h0000_00A5;
        m0_icb_cmd_wmask = 4'hF;
        #2;
        chk("wr s valid", 64'(s_icb_cmd_valid), 64'd1);
        chk("wr s addr", 64'(s_icb_cmd_addr), 64'hF04);
        chk("wr s wdata", 64'(s_icb_cmd_wdata), 64'hA5);
        chk("wr s wmask", 64'(s_icb_cmd_wmask), 64'hF);
        chk("wr s read", 64'(s_icb_cmd_read), 64'd0);
        chk("wr m0 ready", 64'(m0_icb_cmd_ready), 64'd1);
        chk("wr m1 ready", 64'(m1_icb_cmd_ready), 64'd0);
        tick();
        #2;
        chk("wr b2b m0 ready", 64'(m0_icb_cmd_ready), 64'd1);
        chk("wr no rsp", 64'(m0_icb_rsp_valid), 64'd0);
        tick();
        m0_icb_cmd_valid = 1'b0;

        // read with lost response -> error after timeout
        auto_rsp = 1'b0;
        m0_icb_rsp_ready = 1'b0;
        m0_icb_cmd_valid = 1'b1; m0_icb_cmd_read = 1'b1;
        m0_icb_cmd_addr = 32'h40;
        #2;
        chk("to cmd ready", 64'(m0_icb_cmd_ready), 64'd1);
        tick();
        m0_icb_cmd_valid = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            #2;
            chk("to quiet", 64'(m0_icb_rsp_valid), 64'd0);
            tick();
        end
        #2;
        chk("to err valid", 64'(m0_icb_rsp_valid), 64'd1);
        chk("to err flag", 64'(m0_icb_rsp_err), 64'd1);
        chk("to err rdata", 64'(m0_icb_rsp_rdata), 64'd0);
        chk("to m1 quiet", 64'(m1_icb_rsp_valid), 64'd0);
        chk("to s rsp_ready", 64'(s_icb_rsp_ready), 64'd1);
        tick();
        #2;
        chk("to err held", 64'(m0_icb_rsp_valid), 64'd1);
        tick();
        m0_icb_rsp_ready = 1'b1;
        tick();
        m0_icb_cmd_valid = 1'b1; m0_icb_cmd_read = 1'b0;
        m0_icb_cmd_addr = 32'h44;
        #2;
        chk("to next cmd", 64'(m0_icb_cmd_ready), 64'd1);
        tick();
        m0_icb_cmd_valid = 1'b0;

        // late slave response dropped
        s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = 32'h1234;
        #2;
        chk("late s rsp_ready", 64'(s_icb_rsp_ready), 64'd1);
        chk("late m0 quiet", 64'(m0_icb_rsp_valid), 64'd0);
        chk("late m1 quiet", 64'(m1_icb_rsp_valid), 64'd0);
        chk("late m1 rdata", 64'(m1_icb_rsp_rdata), 64'd0);
        tick();

        // reset during WAIT_RSP
        m0_icb_rsp_ready = 1'b0;
        m0_icb_cmd_valid = 1'b1; m0_icb_cmd_read = 1'b1;
        m0_icb_cmd_addr = 32'h80;
        tick();
        m0_icb_cmd_valid = 1'b0;
        m1_icb_cmd_valid = 1'b1; m1_icb_cmd_read = 1'b0;
        #2;
        chk("wait s rsp_ready", 64'(s_icb_rsp_ready), 64'd0);
        chk("wait m1 blocked", 64'(m1_icb_cmd_ready), 64'd0);
        m1_icb_cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst s rsp_ready", 64'(s_icb_rsp_ready), 64'd1);
        chk("arst s cmd_valid", 64'(s_icb_cmd_valid), 64'd0);
        chk("arst m0 rsp_valid", 64'(m0_icb_rsp_valid), 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        auto_rsp = 1'b1;
        m0_icb_rsp_ready = 1'b1;
        s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = 32'h55;
        #2;
        chk("post rst late drop", 64'(m0_icb_rsp_valid), 64'd0);
        tick();
        m0_icb_cmd_valid = 1'b1; m0_icb_cmd_read = 1'b1;
        m0_icb_cmd_addr = 32'h000;
        m1_icb_cmd_valid = 1'b1; m1_icb_cmd_read = 1'b1;
        m1_icb_cmd_addr = 32'h100;
        #2;
        chk("post rst m0 gnt", 64'(m0_icb_cmd_ready), 64'd1);
        chk("post rst m1 wait", 64'(m1_icb_cmd_ready), 64'd0);
        tick();
        m0_icb_cmd_valid = 1'b0;
        m1_icb_cmd_valid = 1'b0;
        repeat (3) tick();

        chk("sb drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
